leb128_encoder: RTL and testbench
=================================

Name: leb128_encoder

Overview:
- Serialises a 64-bit integer into a WebAssembly LEB128 byte stream, signed (SLEB128) or unsigned (ULEB128).
- It is the write-side counterpart of the CPU's LEB128 immediate decoder.
- Used by the test/loader infrastructure to build code images and to produce encoded constants for ROM images.
- One value enters on a valid/ready input port; bytes leave one per handshake on a valid/ready output port.

Parameters:
- DW, 64, input value width in bits; legal values are 32 and 64.
- MAX_BYTES, (DW+6)/7, maximum bytes emitted per value; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a value is offered.
- in_ready  output  1  the encoder can accept a value.
- in_value  input  DW  integer to encode.
- in_signed  input  1  1 = SLEB128, 0 = ULEB128.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  the consumer takes out_byte this cycle.
- out_byte  output  8  encoded byte; bit7 is the continuation flag.
- out_last  output  1  out_byte is the final byte of the value.
- out_index  output  4  0-based position of out_byte within the value.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_byte=0, out_last=0, out_index=0, state=IDLE. Internal shift register and signed flag are cleared to 0.
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - When in_valid & in_ready, latch in_value into shift register R and latch in_signed, then go to EMIT.
  - The first byte is presented the cycle after acceptance (1-cycle latency).
- EMIT:
  - in_ready=0.
  - out_valid=1 and holds until out_ready; out_byte, out_last and out_index are stable while stalled.
- Byte formation:
  - low7 = R[6:0].
  - next = R >> 7; the shift is arithmetic when the signed flag is set, logical otherwise.
- Termination test, evaluated on the current R:
  - Unsigned: last = (next == 0).
  - Signed: last = (next == 0 and R[6] == 0) or (next == all-ones and R[6] == 1).
- out_byte = {~last, low7}.
- On out_valid & out_ready:
  - If not last: R <= next, out_index increments.
  - If last: return to IDLE and out_index <= 0. in_ready rises in the following cycle; there is no same-cycle re-accept.
- out_index never exceeds MAX_BYTES-1. For DW=64 an unsigned all-ones input yields exactly 10 bytes, and the termination test guarantees this bound.
- Combinational outputs: out_byte and out_last may be derived combinationally from R; out_valid and in_ready come directly from state.
- Reset in any state: the in-progress stream is abandoned. The next cycle shows out_valid=0 and in_ready=1; no partial byte is completed.
- in_valid is ignored in EMIT. in_value and in_signed are don't-care outside the accept cycle.

Optional Feature:
- Macro: LEB128_ENC_WRAP32_EN.
- When defined:
  - An extra input port in_i32 (1 bit) is added.
  - When in_i32=1 at accept, only in_value[31:0] is latched. It is sign-extended (in_signed=1) or zero-extended (in_signed=0) to DW bits, matching i32.wrap-i64 semantics.
  - The encoding is therefore at most 5 bytes.
- When undefined: the port is absent and all DW bits are always encoded.

Test Plan:
- Unsigned 624485 with out_ready held 1 -> bytes E5, 8E, 26; out_last only on 26; out_index 0,1,2; in_ready returns 1 one cycle after the 26 handshake.
- Signed -123456 -> C0, BB, 78. Signed -1 -> single byte 7F with out_last=1. Signed 64 -> C0, 00.
- Unsigned 0 -> single byte 00. Unsigned 0xFFFF_FFFF_FFFF_FFFF (DW=64) -> nine FF then 01; out_index reaches 9.
- Backpressure: unsigned 300 with out_ready toggling 0,1,0,0,1 -> out_byte AC held stable while stalled, then 02; exactly 2 handshakes; in_ready=0 throughout EMIT even with in_valid=1.
- Reset mid-stream: assert reset after the first byte of unsigned 624485 -> next cycle out_valid=0, in_ready=1, out_index=0; a new value 42 then encodes as 2A.
- LEB128_ENC_WRAP32_EN: in_i32=1, in_signed=1, in_value=0xFFFFFFFF_0000002A -> single byte 2A. in_i32=1, in_signed=1, in_value=0x00000000_FFFFFFFF -> 7F.

Source files
------------

// File: rtl/leb128_encoder.sv
// Serialises a DW-bit integer into an unsigned or signed LEB128 byte stream, one byte per handshake.
// Optional macro LEB128_ENC_WRAP32_EN adds in_i32, which encodes only the low 32 bits (sign/zero-extended).
module leb128_encoder #(
  parameter int DW        = 64,
  parameter int MAX_BYTES = (DW + 6) / 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_value,
  input  logic          in_signed,
`ifdef LEB128_ENC_WRAP32_EN
  input  logic          in_i32,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_byte,
  output logic          out_last,
  output logic [3:0]    out_index
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [3:0] LAST_INDEX = 4'(MAX_BYTES - 1);

  logic [0:0]    state_reg, state_next;
  logic [DW-1:0] shift_reg, shift_next;
  logic          signed_reg, signed_next;
  logic [3:0]    index_reg, index_next;

  logic [DW-1:0] load_value;
  logic [DW-1:0] rest_value;
  logic          fill_bit;
  logic          last_byte;

`ifdef LEB128_ENC_WRAP32_EN
  // Upper bits are replaced by the extension of bit 31 when a 32-bit value is requested.
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_load
      if (gi < 32) begin : g_low
        assign load_value[gi] = in_value[gi];
      end else begin : g_high
        assign load_value[gi] = in_i32 ? (in_signed & in_value[31]) : in_value[gi];
      end
    end
  endgenerate
`else
  assign load_value = in_value;
`endif

  // Explicit fill avoids relying on expression signedness for the arithmetic shift.
  assign fill_bit   = signed_reg & shift_reg[DW-1];
  assign rest_value = {{7{fill_bit}}, shift_reg[DW-1:7]};

  always_comb begin
    if (signed_reg) begin
      last_byte = ((rest_value == '0) && !shift_reg[6]) ||
                  ((&rest_value) && shift_reg[6]);
    end else begin
      last_byte = (rest_value == '0);
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == EMIT);
  assign out_byte  = (state_reg == EMIT) ? {~last_byte, shift_reg[6:0]} : 8'h00;
  assign out_last  = (state_reg == EMIT) && last_byte;
  assign out_index = index_reg;

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    signed_next = signed_reg;
    index_next  = index_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next  = EMIT;
          shift_next  = load_value;
          signed_next = in_signed;
          index_next  = 4'd0;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_byte) begin
            state_next = IDLE;
            index_next = 4'd0;
          end else begin
            shift_next = rest_value;
            if (index_reg < LAST_INDEX) begin
              index_next = index_reg + 4'd1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      signed_reg <= 1'b0;
      index_reg  <= 4'd0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      signed_reg <= signed_next;
      index_reg  <= index_next;
    end
  end

endmodule

// File: tb/tb_leb128_encoder.sv
// Self-checking bench for leb128_encoder: vector table through a byte scoreboard, plus
// latency, backpressure and mid-stream reset sequences.
module tb_leb128_encoder;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_value;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic          out_last;
  logic [3:0]    out_index;
`ifdef LEB128_ENC_WRAP32_EN
  logic          in_i32;
`endif

  leb128_encoder #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_signed (in_signed),
`ifdef LEB128_ENC_WRAP32_EN
    .in_i32    (in_i32),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_index (out_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [3:0] idx;
  } exp_t;

  typedef struct {
    string           name;
    logic [63:0]     value;
    bit              sgn;
    bit              i32;
    int              n;
    logic [0:9][7:0] b;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   handshakes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [63:0] value, input bit sgn,
                              input bit i32, input int n, input logic [79:0] bytes);
    vec_t v;
    v.name  = name;
    v.value = value;
    v.sgn   = sgn;
    v.i32   = i32;
    v.n     = n;
    v.b     = bytes << (8 * (10 - n));
    return v;
  endfunction

  // Scoreboard consumer: every real handshake pops one expected byte.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      handshakes++;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_byte: got %02h, expected none", out_byte);
      end else begin
        e = sb.pop_front();
        check("out_byte", {56'h0, out_byte}, {56'h0, e.b});
        check("out_last", {63'h0, out_last}, {63'h0, e.last});
        check("out_index", {60'h0, out_index}, {60'h0, e.idx});
        $display("byte idx=%0d data=%02h last=%0b", out_index, out_byte, out_last);
      end
    end
  end

  // Waits for in_ready, offers the value for one cycle and queues its expected bytes.
  task automatic send(input vec_t v);
    int cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("in_ready_wait", {63'h0, in_ready}, 64'd1);
    in_value  = v.value;
    in_signed = v.sgn;
`ifdef LEB128_ENC_WRAP32_EN
    in_i32    = v.i32;
`endif
    in_valid  = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      sb.push_back('{b: v.b[i], last: (i == v.n - 1), idx: 4'(i)});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    while (sb.size() != 0 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    check("in_ready_after_last", {63'h0, in_ready}, 64'd1);
    check("out_valid_after_last", {63'h0, out_valid}, 64'd0);
  endtask

  initial begin
    bit         pat[5];
    logic [7:0] expb[5];
    int         hs0;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
`ifdef LEB128_ENC_WRAP32_EN
    in_i32    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'h0, in_ready}, 64'd1);
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_out_byte", {56'h0, out_byte}, 64'd0);
    check("rst_out_last", {63'h0, out_last}, 64'd0);
    check("rst_out_index", {60'h0, out_index}, 64'd0);
    reset = 1'b0;

    vecs.push_back(mk("u_624485", 64'd624485, 0, 0, 3, 80'hE58E26));
    vecs.push_back(mk("s_-123456", 64'hFFFF_FFFF_FFFE_1DC0, 1, 0, 3, 80'hC0BB78));
    vecs.push_back(mk("s_-1", 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 80'h7F));
    vecs.push_back(mk("s_64", 64'd64, 1, 0, 2, 80'hC000));
    vecs.push_back(mk("s_63", 64'd63, 1, 0, 1, 80'h3F));
    vecs.push_back(mk("s_-64", 64'hFFFF_FFFF_FFFF_FFC0, 1, 0, 1, 80'h40));
    vecs.push_back(mk("s_-65", 64'hFFFF_FFFF_FFFF_FFBF, 1, 0, 2, 80'hBF7F));
    vecs.push_back(mk("u_0", 64'd0, 0, 0, 1, 80'h00));
    vecs.push_back(mk("u_127", 64'd127, 0, 0, 1, 80'h7F));
    vecs.push_back(mk("u_128", 64'd128, 0, 0, 2, 80'h8001));
    vecs.push_back(mk("u_all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 10, 80'hFFFFFFFFFFFFFFFFFF01));
    vecs.push_back(mk("s_max", 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 10, 80'hFFFFFFFFFFFFFFFFFF00));
    vecs.push_back(mk("s_min", 64'h8000_0000_0000_0000, 1, 0, 10, 80'h8080808080808080807F));
    vecs.push_back(mk("u_300", 64'd300, 0, 0, 2, 80'hAC02));
`ifdef LEB128_ENC_WRAP32_EN
    vecs.push_back(mk("w32_s_2a", 64'hFFFF_FFFF_0000_002A, 1, 1, 1, 80'h2A));
    vecs.push_back(mk("w32_s_neg1", 64'h0000_0000_FFFF_FFFF, 1, 1, 1, 80'h7F));
    vecs.push_back(mk("w32_u_ff", 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 5, 80'hFFFFFFFF0F));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      $display("vector %s value=%016h signed=%0b", vecs[i].name, vecs[i].value, vecs[i].sgn);
      send(vecs[i]);
      check("first_byte_latency", {63'h0, out_valid}, 64'd1);
      check("in_ready_in_emit", {63'h0, in_ready}, 64'd0);
      drain();
    end

    // Backpressure: out_byte must hold while stalled; in_valid is ignored during EMIT.
    $display("sequence backpressure u_300");
    pat  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    expb = '{8'hAC, 8'hAC, 8'h02, 8'h02, 8'h02};
    out_ready = 1'b0;
    send(mk("u_300_bp", 64'd300, 0, 0, 2, 80'hAC02));
    hs0 = handshakes;
    in_valid = 1'b1;
    in_value = 64'd7;
    for (int k = 0; k < 5; k++) begin
      out_ready = pat[k];
      check("bp_in_ready", {63'h0, in_ready}, 64'd0);
      check("bp_out_valid", {63'h0, out_valid}, 64'd1);
      check("bp_out_byte", {56'h0, out_byte}, {56'h0, expb[k]});
      if (k == 4) in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    check("bp_handshakes", 64'(handshakes - hs0), 64'd2);
    check("bp_in_ready_after", {63'h0, in_ready}, 64'd1);
    check("bp_out_valid_after", {63'h0, out_valid}, 64'd0);
    out_ready = 1'b1;

    // Reset after the first byte abandons the stream.
    $display("sequence reset mid-stream u_624485");
    send(mk("u_624485_rst", 64'd624485, 0, 0, 3, 80'hE58E26));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    check("rst_mid_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_mid_in_ready", {63'h0, in_ready}, 64'd1);
    check("rst_mid_out_index", {60'h0, out_index}, 64'd0);
    check("rst_mid_out_byte", {56'h0, out_byte}, 64'd0);
    send(mk("u_42", 64'd42, 0, 0, 1, 80'h2A));
    check("u42_byte", {56'h0, out_byte}, 64'h2A);
    check("u42_last", {63'h0, out_last}, 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
